// File: rtl/day_number_entry.sv
// Pushbutton entry stage: syncs and debounces two active-low keys, then runs
// a three-state FSM that builds and commits a two-digit decimal number.
module day_number_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] KEY,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [6:0] num_total,
  output logic       num_valid,
  output logic       edit_tens,
  output logic       edit_ones
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_TENS, S_ONES, S_DONE} state_t;

  // Synchroniser stores the inverted key so a cleared flop means "released".
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_prev_q, press_q;
  logic [1:0][CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= ~KEY;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_q[i] <= ~stable_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i]    <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  state_t     state_q, state_d;
  logic [3:0] digit1_q, digit1_d, digit2_q, digit2_d;
  logic [6:0] num_total_q, num_total_d;
  logic       num_valid_q, edit_tens_q, edit_ones_q;
  logic       inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_TENS;
      digit1_q    <= '0;
      digit2_q    <= '0;
      num_total_q <= '0;
      num_valid_q <= 1'b0;
      edit_tens_q <= 1'b1;
      edit_ones_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit1_q    <= digit1_d;
      digit2_q    <= digit2_d;
      num_total_q <= num_total_d;
      num_valid_q <= (state_d == S_DONE);
      edit_tens_q <= (state_d == S_TENS);
      edit_ones_q <= (state_d == S_ONES);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TENS:  if (press_q[1]) state_d = S_ONES;
      S_ONES:  if (press_q[1]) state_d = S_DONE;
      S_DONE:  if (press_q[1]) state_d = S_TENS;
      default: state_d = S_TENS;
    endcase
  end

  // The advance key wins a same-cycle tie, so the increment is masked by it.
  always_comb begin
    inc         = press_q[0] & ~press_q[1];
    digit1_d    = digit1_q;
    digit2_d    = digit2_q;
    num_total_d = num_total_q;
    if (state_q == S_TENS && inc)
      digit1_d = (digit1_q == 4'd9) ? 4'd0 : digit1_q + 4'd1;
    if (state_q == S_ONES && inc)
      digit2_d = (digit2_q == 4'd9) ? 4'd0 : digit2_q + 4'd1;
    if (state_q == S_ONES && press_q[1])
      num_total_d = ({3'b000, digit1_q} << 3) + ({3'b000, digit1_q} << 1)
                  + {3'b000, digit2_q};
  end

  assign digit1    = digit1_q;
  assign digit2    = digit2_q;
  assign num_total = num_total_q;
  assign num_valid = num_valid_q;
  assign edit_tens = edit_tens_q;
  assign edit_ones = edit_ones_q;

endmodule

// File: tb/tb_day_number_entry.sv
// Directed bench for day_number_entry with DEBOUNCE_CYCLES = 4; expected
// output snapshots go through a scoreboard queue and are checked by assertions.
module tb_day_number_entry;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic [3:0] digit1, digit2;
  logic [6:0] num_total;
  logic       num_valid, edit_tens, edit_ones;

  day_number_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .KEY(KEY),
    .digit1(digit1), .digit2(digit2), .num_total(num_total),
    .num_valid(num_valid), .edit_tens(edit_tens), .edit_ones(edit_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] d1, d2;
    logic [6:0] nt;
    logic       v, t, o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int d1, input int d2, input int nt,
                      input bit v, input bit t, input bit o);
    exp_t e;
    e.tag = tag; e.d1 = 4'(d1); e.d2 = 4'(d2); e.nt = 7'(nt);
    e.v = v; e.t = t; e.o = o;
    sb.push_back(e);
  endtask

  // Called at a negedge: compares the oldest expectation to the DUT outputs.
  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".digit1"},    {4'b0, digit1},    {4'b0, e.d1});
    cmp({e.tag, ".digit2"},    {4'b0, digit2},    {4'b0, e.d2});
    cmp({e.tag, ".num_total"}, {1'b0, num_total}, {1'b0, e.nt});
    cmp({e.tag, ".num_valid"}, {7'b0, num_valid}, {7'b0, e.v});
    cmp({e.tag, ".edit_tens"}, {7'b0, edit_tens}, {7'b0, e.t});
    cmp({e.tag, ".edit_ones"}, {7'b0, edit_ones}, {7'b0, e.o});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: low for N+4 edges (result visible on the last), then release.
  task automatic press(input int k, input string tag, input int d1, input int d2,
                       input int nt, input bit v, input bit t, input bit o);
    push(tag, d1, d2, nt, v, t, o);
    KEY[k] = 1'b0;
    cycles(N + 4);
    check();
    KEY[k] = 1'b1;
    cycles(2 * N + 4);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cycles(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 2'b11;
    @(negedge clk);

    // Reset state, then stability through idle cycles
    push("reset", 0, 0, 0, 0, 1, 0);
    do_reset(3);
    check();
    push("idle50", 0, 0, 0, 0, 1, 0);
    cycles(50);
    check();

    // Bounce rejection: 3 low / 1 high, ten times
    for (int i = 0; i < 10; i++) begin
      KEY[0] = 1'b0; cycles(3);
      KEY[0] = 1'b1; cycles(1);
    end
    cycles(10);
    push("bounce", 0, 0, 0, 0, 1, 0);
    check();

    // Long hold: exactly N+4 edges latency, one increment only
    KEY[0] = 1'b0;
    push("lat_pre", 0, 0, 0, 0, 1, 0);
    cycles(N + 3);
    check();
    push("lat_hit", 1, 0, 0, 0, 1, 0);
    cycles(1);
    check();
    cycles(20 - (N + 4));
    KEY[0] = 1'b1;
    cycles(12);
    push("hold_once", 1, 0, 0, 0, 1, 0);
    check();

    // Wrap of tens digit from a fresh reset
    do_reset(1);
    for (int i = 1; i <= 10; i++)
      press(0, $sformatf("wrap%0d", i), i % 10, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++)
      press(0, $sformatf("wrap_more%0d", i), i, 0, 0, 0, 1, 0);

    // Full entry of 47
    press(1, "to_ones", 4, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 7; i++)
      press(0, $sformatf("ones%0d", i), 4, i, 0, 0, 0, 1);
    KEY[1] = 1'b0;
    push("commit_pre", 4, 7, 0, 0, 0, 1);
    cycles(N + 3);
    check();
    push("commit", 4, 7, 47, 1, 0, 0);
    cycles(1);
    check();
    KEY[1] = 1'b1;
    cycles(2 * N + 4);
    press(0, "done_ignore", 4, 7, 47, 1, 0, 0);
    press(1, "back_tens", 4, 7, 47, 0, 1, 0);

    // Bring tens to 2 (4 + 8 wraps), then press both keys together
    for (int i = 1; i <= 8; i++)
      press(0, $sformatf("to2_%0d", i), (4 + i) % 10, 7, 47, 0, 1, 0);
    KEY = 2'b00;
    push("simul", 2, 7, 47, 0, 0, 1);
    cycles(N + 4);
    check();
    KEY = 2'b11;
    cycles(2 * N + 4);

    // Ones digit to 5 (7 + 8 wraps), then reset mid-debounce
    for (int i = 1; i <= 8; i++)
      press(0, $sformatf("to5_%0d", i), 2, (7 + i) % 10, 47, 0, 0, 1);
    KEY[0] = 1'b0;
    cycles(4);
    push("mid_reset", 0, 0, 0, 0, 1, 0);
    do_reset(1);
    check();
    push("post_pre", 0, 0, 0, 0, 1, 0);
    cycles(N + 3);
    check();
    push("post_hit", 1, 0, 0, 0, 1, 0);
    cycles(1);
    check();
    KEY[0] = 1'b1;
    cycles(12);

    cmp("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
